// File: rtl/fetch_predecoder.sv
// Registered fetch pre-decode stage: finds the oldest control-flow slot, truncates the bundle, emits one redirect.
// Optional return-address stack is built when PREDEC_RAS_EN is defined.
module fetch_predecoder #(
  parameter int FETCH_WIDTH = 3,
  parameter int RAS_DEPTH   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [32*FETCH_WIDTH-1:0] inst,
  input  logic [32*FETCH_WIDTH-1:0] pc,
  input  logic [FETCH_WIDTH-1:0]    bpu_valid,
  input  logic [32*FETCH_WIDTH-1:0] bpu_target,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [32*FETCH_WIDTH-1:0] out_inst,
  output logic [32*FETCH_WIDTH-1:0] out_pc,
  output logic [FETCH_WIDTH-1:0]    out_slot_valid,
  output logic                      redirect_valid,
  output logic [31:0]               redirect_target,
  output logic                      redirect_is_direct
);

  // Handshake: a bundle moves into the register when in_valid & in_ready and no flush;
  // it leaves on out_valid & out_ready, and both may happen on the same edge.
  logic                   accept;
  logic                   any_ctrl;
  logic                   sel_direct;
  logic [31:0]            sel_target;
  logic [FETCH_WIDTH-1:0] slot_mask;
  logic [31:0]            w;
  logic [31:0]            p;
  logic                   is_b;
  logic                   is_bl;
  logic                   is_ret;
  logic                   ras_ok;
  logic [31:0]            ras_top;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready & ~flush;

`ifdef PREDEC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [31:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0] ras_ptr;
  logic [CW-1:0] ras_count;
  logic          sel_bl;
  logic          sel_ret;
  logic [31:0]   sel_pc;
  logic          push;
  logic          pop;

  // ras_ptr names the next free entry, so the top lives one below it.
  assign ras_ok  = ras_count != '0;
  assign ras_top = ras_mem[ras_ptr - PW'(1)];
  assign push    = accept & any_ctrl & sel_bl;
  assign pop     = accept & any_ctrl & sel_ret;

  always_ff @(posedge clk) begin
    if (push) ras_mem[ras_ptr] <= sel_pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ras_ptr   <= '0;
      ras_count <= '0;
    end else if (push) begin
      ras_ptr <= ras_ptr + PW'(1);
      if (ras_count != CW'(RAS_DEPTH)) ras_count <= ras_count + CW'(1);
    end else if (pop) begin
      ras_ptr   <= ras_ptr - PW'(1);
      ras_count <= ras_count - CW'(1);
    end
  end
`else
  assign ras_ok  = 1'b0;
  assign ras_top = 32'h0;
`endif

  // Scan from the youngest slot down so the last hit left standing is the oldest one.
  always_comb begin
    any_ctrl   = 1'b0;
    sel_direct = 1'b0;
    sel_target = 32'h0;
    slot_mask  = '1;
    w          = 32'h0;
    p          = 32'h0;
    is_b       = 1'b0;
    is_bl      = 1'b0;
    is_ret     = 1'b0;
`ifdef PREDEC_RAS_EN
    sel_bl     = 1'b0;
    sel_ret    = 1'b0;
    sel_pc     = 32'h0;
`endif
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      w      = inst[32*i +: 32];
      p      = pc[32*i +: 32];
      is_b   = w[31:26] == 6'b010100;
      is_bl  = w[31:26] == 6'b010101;
      is_ret = (w == 32'h4C000020) & ras_ok;
      if (is_b | is_bl | is_ret | bpu_valid[i]) begin
        any_ctrl   = 1'b1;
        sel_direct = is_b | is_bl;
`ifdef PREDEC_RAS_EN
        sel_bl     = is_bl;
        sel_ret    = is_ret;
        sel_pc     = p;
`endif
        if (is_b | is_bl) sel_target = p + {{4{w[9]}}, w[9:0], w[25:10], 2'b00};
        else if (is_ret)  sel_target = ras_top;
        else              sel_target = bpu_target[32*i +: 32];
        for (int j = 0; j < FETCH_WIDTH; j++) slot_mask[j] = (j <= i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid          <= 1'b0;
      out_inst           <= '0;
      out_pc             <= '0;
      out_slot_valid     <= '0;
      redirect_valid     <= 1'b0;
      redirect_target    <= 32'h0;
      redirect_is_direct <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid          <= 1'b1;
      out_inst           <= inst;
      out_pc             <= pc;
      out_slot_valid     <= slot_mask;
      redirect_valid     <= any_ctrl;
      redirect_target    <= sel_target;
      redirect_is_direct <= any_ctrl & sel_direct;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
